// File: rtl/dma_channel_ctrl.sv
// Single-channel DMA engine: moves bytes between an IO device and RAM as bus master.
// Outputs are registered and derived from the next FSM state, so each one lines up with the state it belongs to.
module dma_channel_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [15:0]       cfg_wdata,
    input  logic              DREQ0,
    input  logic              HLDA,
    input  logic              READY,
    input  logic [DATA_W-1:0] data_in,
    output logic              HRQ,
    output logic              DACK0,
    output logic [1:0]        AEN,
    output logic              IOR,
    output logic              IOW,
    output logic              MEMR,
    output logic              MEMW,
    output logic              READY_MEM,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              TC,
    output logic              busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_IORD, S_MEMWR, S_MEMRD, S_MEMCAP, S_IOWR, S_IOHOLD, S_NEXT
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    state_t              w_xfer_state;
    logic [ADDR_W-1:0]   r_base_addr;
    logic [CNT_W-1:0]    r_base_cnt;
    logic [3:0]          r_mode;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [CNT_W-1:0]    r_cur_cnt;
    logic [DATA_W-1:0]   r_byte;
    logic                r_busy;

    logic                r_hrq, r_dack0, r_ior, r_iow, r_memr, r_memw, r_ready_mem, r_data_oe, r_tc;
    logic [1:0]          r_aen;
    logic [ADDR_W-1:0]   r_addr_out;
    logic [DATA_W-1:0]   r_data_out;

    logic [ADDR_W-1:0]   w_addr_next;
    logic [ADDR_W-1:0]   w_step_addr;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [DATA_W-1:0]   w_byte_next;
    logic                w_busy_next;
    logic                w_abort;
    logic                w_arm;
    logic                w_last;

    assign w_abort      = cfg_we && (cfg_sel == 2'd3) && cfg_wdata[1];
    assign w_arm        = cfg_we && (cfg_sel == 2'd3) && cfg_wdata[0] && !cfg_wdata[1];
    assign w_last       = (r_cur_cnt == '0);
    assign w_step_addr  = r_mode[1] ? (r_cur_addr - ADDR_W'(1)) : (r_cur_addr + ADDR_W'(1));
    assign w_xfer_state = r_mode[0] ? S_MEMRD : S_IORD;

    always_comb begin
        w_state_next = r_state;
        w_byte_next  = r_byte;
        w_addr_next  = r_cur_addr;
        w_cnt_next   = r_cur_cnt;
        w_busy_next  = r_busy;
        case (r_state)
            S_IDLE:   if (r_busy && DREQ0) w_state_next = S_REQ;
            S_REQ:    if (HLDA) w_state_next = w_xfer_state;
            S_IORD: begin
                if (READY) begin
                    w_byte_next  = data_in;
                    w_state_next = S_MEMWR;
                end
            end
            S_MEMWR:  w_state_next = S_NEXT;
            S_MEMRD:  w_state_next = S_MEMCAP;
            S_MEMCAP: begin
                w_byte_next  = data_in;
                w_state_next = S_IOWR;
            end
            S_IOWR:   if (READY) w_state_next = S_IOHOLD;
            S_IOHOLD: w_state_next = S_NEXT;
            S_NEXT: begin
                w_addr_next = w_step_addr;
                if (w_last) begin
                    w_state_next = S_IDLE;
                    if (r_mode[2]) begin
                        w_addr_next = r_base_addr;
                        w_cnt_next  = r_base_cnt;
                    end else begin
                        w_busy_next = 1'b0;
                    end
                end else begin
                    w_cnt_next   = r_cur_cnt - CNT_W'(1);
                    // Block mode chains straight into the next byte without re-arbitrating
                    w_state_next = (r_mode[3] && DREQ0) ? w_xfer_state : S_IDLE;
                end
            end
            default:  w_state_next = S_IDLE;
        endcase
        // Abort freezes the address/count where they stand and never produces TC
        if (w_abort) begin
            w_state_next = S_IDLE;
            w_addr_next  = r_cur_addr;
            w_cnt_next   = r_cur_cnt;
            w_busy_next  = 1'b0;
        end else if (w_arm) begin
            w_addr_next  = r_base_addr;
            w_cnt_next   = r_base_cnt;
            w_busy_next  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_base_addr <= '0;
            r_base_cnt  <= '0;
            r_mode      <= '0;
            r_cur_addr  <= '0;
            r_cur_cnt   <= '0;
            r_byte      <= '0;
            r_busy      <= 1'b0;
            r_hrq       <= 1'b0;
            r_dack0     <= 1'b0;
            r_aen       <= 2'd0;
            r_ior       <= 1'b0;
            r_iow       <= 1'b0;
            r_memr      <= 1'b0;
            r_memw      <= 1'b0;
            r_ready_mem <= 1'b0;
            r_addr_out  <= '0;
            r_data_out  <= '0;
            r_data_oe   <= 1'b0;
            r_tc        <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_byte     <= w_byte_next;
            r_cur_addr <= w_addr_next;
            r_cur_cnt  <= w_cnt_next;
            r_busy     <= w_busy_next;
            if (cfg_we && !r_busy) begin
                case (cfg_sel)
                    2'd0:    r_base_addr <= cfg_wdata[ADDR_W-1:0];
                    2'd1:    r_base_cnt  <= cfg_wdata[CNT_W-1:0];
                    2'd2:    r_mode      <= cfg_wdata[3:0];
                    default: ;
                endcase
            end
            r_hrq       <= (w_state_next != S_IDLE);
            r_dack0     <= (w_state_next != S_IDLE) && (w_state_next != S_REQ);
            r_ior       <= (w_state_next inside {S_IORD, S_MEMWR});
            r_iow       <= (w_state_next inside {S_IOWR, S_IOHOLD});
            r_memr      <= (w_state_next == S_MEMRD);
            r_memw      <= (w_state_next == S_MEMWR);
            r_ready_mem <= (w_state_next == S_MEMWR);
            r_data_oe   <= (w_state_next inside {S_MEMWR, S_IOWR, S_IOHOLD});
            r_tc        <= (w_state_next == S_NEXT) && w_last;
            if (w_state_next == S_IORD)
                r_aen <= 2'd3;
            else if (w_state_next inside {S_MEMWR, S_MEMRD, S_MEMCAP, S_IOWR, S_IOHOLD})
                r_aen <= 2'd1;
            else
                r_aen <= 2'd0;
            r_addr_out <= (w_state_next inside {S_MEMWR, S_MEMRD, S_MEMCAP}) ? w_addr_next : '0;
            r_data_out <= (w_state_next inside {S_MEMWR, S_IOWR, S_IOHOLD}) ? w_byte_next : '0;
        end
    end

    assign HRQ       = r_hrq;
    assign DACK0     = r_dack0;
    assign AEN       = r_aen;
    assign IOR       = r_ior;
    assign IOW       = r_iow;
    assign MEMR      = r_memr;
    assign MEMW      = r_memw;
    assign READY_MEM = r_ready_mem;
    assign addr_out  = r_addr_out;
    assign data_out  = r_data_out;
    assign data_oe   = r_data_oe;
    assign TC        = r_tc;
    assign busy      = r_busy;

endmodule

// File: doc/dma_channel_ctrl.md
Name: dma_channel_ctrl

Overview:
Single-channel DMA transfer engine and bus master. It is the initiator side of the IO-device handshake: it drives IOR/IOW, the AEN bus-phase code and READY_MEM, and consumes the device's READY. It moves bytes between the 16-entry IO device and system RAM in either direction after programming from the CPU register port. It sits between the CPU (HRQ/HLDA arbitration), RAM (MEMR/MEMW) and the IO device (DREQ0/DACK0).

Parameters:
ADDR_W, 16, memory address width
DATA_W, 8, data byte width
CNT_W, 16, transfer count width

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
cfg_we  in  1  CPU register write strobe
cfg_sel  in  2  register select: 0 base addr, 1 base count, 2 mode, 3 command
cfg_wdata  in  16  register write data
DREQ0  in  1  IO device transfer request
HLDA  in  1  CPU hold acknowledge
READY  in  1  IO device handshake (data valid on read / slot ready on write)
data_in  in  8  bus read data (IO data in AEN=3 phase, RAM data after MEMR)
HRQ  out  1  hold request to CPU
DACK0  out  1  DMA acknowledge to IO device
AEN  out  2  bus phase: 0 CPU owns bus, 1 DMA drives addr/data, 3 IO device drives bus
IOR  out  1  IO read command
IOW  out  1  IO write command
MEMR  out  1  RAM read pulse
MEMW  out  1  RAM write pulse
READY_MEM  out  1  memory-side completion acknowledge to IO device
addr_out  out  16  memory address driven when AEN=1
data_out  out  8  write data driven when AEN=1
data_oe  out  1  data_out valid on bus
TC  out  1  terminal count, one-cycle pulse
busy  out  1  channel armed or transferring

Behaviour:
- Reset (sync, active-high): all outputs 0, AEN=0. Registers cleared. FSM=IDLE. Reset wins over all other inputs, including mid-transfer.
- Mode reg bits:
  - [0] dir: 0 IO->mem, 1 mem->IO
  - [1] decrement address
  - [2] auto-init
  - [3] block mode (0 = single)
- Command reg:
  - bit0=1 arms the channel: cur_addr<=base_addr, cur_cnt<=base_cnt, busy=1.
  - bit1=1 aborts.
  - Abort has priority over arm.
- cfg writes to sel 0-2 while busy=1 are ignored. Abort is always accepted.
- Count semantics: cur_cnt+1 bytes are transferred. base_cnt=0 transfers 1 byte.
- FSM states: IDLE, REQ, IORD, MEMWR, MEMRD, MEMCAP, IOWR, IOHOLD, NEXT.
- IDLE:
  - If busy and DREQ0=1: HRQ<=1, go to REQ.
- REQ:
  - Hold HRQ=1 until HLDA=1.
  - Then DACK0<=1 and go to IORD (dir=0) or MEMRD (dir=1).
- IORD:
  - AEN=3, IOR=1. Wait for READY=1.
  - On that cycle latch data_in into the byte register, go to MEMWR.
- MEMWR (1 cycle):
  - AEN=1, addr_out=cur_addr, data_out=latched byte, data_oe=1, MEMW=1, READY_MEM=1, IOR stays 1.
  - Then go to NEXT.
- MEMRD (1 cycle):
  - AEN=1, addr_out=cur_addr, MEMR=1. Go to MEMCAP.
- MEMCAP (1 cycle):
  - RAM data is valid in data_in one cycle after MEMR. Latch data_in, go to IOWR.
- IOWR:
  - AEN=1, data_oe=1, IOW=1. Wait for READY=1, then go to IOHOLD.
- IOHOLD (1 cycle):
  - AEN=1, data_oe=1, IOW=1, so the device samples the byte on its second IOW cycle.
  - Go to NEXT.
- NEXT (1 cycle): all strobes 0.
  - cur_addr +/- 1, mod 2^16 (0xFFFF+1=0x0000, 0x0000-1=0xFFFF).
  - If cur_cnt==0: TC=1 for this cycle.
    - Auto-init=1: reload cur_addr/cur_cnt from base, busy stays 1.
    - Auto-init=0: busy<=0.
    - In both cases HRQ<=0, DACK0<=0, go to IDLE.
  - Else cur_cnt-1:
    - Block mode with DREQ0=1: keep HRQ/DACK0, go directly to the next IORD/MEMRD.
    - Otherwise: drop HRQ/DACK0, go to IDLE. This gives at least 1 idle cycle between bytes and re-arbitrates.
- DREQ0 deasserting mid-byte does not cancel that byte. It is only sampled in IDLE and NEXT.
- HLDA dropping after grant is ignored until the current byte completes.
- Abort in any state: next cycle FSM=IDLE, all outputs 0, busy=0, no TC, cur_addr/cur_cnt frozen.
- READY is ignored in all states except IORD and IOWR.
- No timeout: a device that never raises READY stalls the channel until abort or reset.

Test Plan:
- Reset mid-IORD (IOR=1) -> next cycle all outputs 0, AEN=0, busy=0.
- IO->mem single mode:
  - Stimulus: base_addr=0x0100, base_cnt=3, DREQ0 held, HLDA=1 one cycle after HRQ, device gives READY with bytes 0..3.
  - Required: RAM 0x0100-0x0103 = 0,1,2,3; HRQ drops between bytes; TC pulses once, after the 4th MEMW; busy=0.
- mem->IO block mode:
  - Stimulus: base_addr=0x0005, base_cnt=1, decrement, RAM[5]=0xA5, RAM[4]=0x5A.
  - Required: IOW data 0xA5 then 0x5A; HRQ stays high between bytes; final cur_addr=0x0003.
- Address wrap: base_addr=0xFFFF, base_cnt=1, increment -> MEMW at 0xFFFF then 0x0000.
- Auto-init: base_cnt=0, autoinit=1, two DREQ0 bursts -> two TC pulses, both MEMW at base_addr, busy stays 1.
- Abort while waiting on READY in IOWR -> next cycle IOW=0, HRQ=0, busy=0, no TC; mode write on the following cycle is accepted.
